rsg_sequence_arbiter: RTL and testbench
=======================================

Name: rsg_sequence_arbiter

Overview:
Arbitrates one shared READY/SET/GO sequence among N_REQ requesters. Requesters are served in round-robin order.
For the granted requester, the block runs timed phases: READY, then SET, then GO. It then pulses done and releases the grant.
Sits between client request logic and the downstream blocks that consume get_ready/get_set/get_going.
Phase dwell times are programmable through static config inputs.

Parameters:
N_REQ, 4, number of requesters (2..16)
CNT_W, 8, width of the phase dwell counters and the config inputs

Ports:
clk  input  1  system clock, all logic on posedge
rstN  input  1  asynchronous active-low reset
req  input  N_REQ  level request per requester; must stay high until done or abort
abort  input  1  synchronous abort of the active sequence
ready_cycles  input  CNT_W  READY phase dwell in cycles
set_cycles  input  CNT_W  SET phase dwell in cycles
go_cycles  input  CNT_W  GO phase dwell in cycles
grant  output  N_REQ  one-hot owner of the sequence; all zero when idle
get_ready  output  1  high throughout the READY phase
get_set  output  1  high throughout the SET phase
get_going  output  1  high throughout the GO phase
done  output  1  one-cycle pulse when a sequence completes normally
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rstN low, asynchronous): state=IDLE, grant=0, counter=0, RR pointer=0 (req[0] highest priority). All outputs 0.
- State encoding, Johnson: IDLE=3'b000, READY=3'b001, SET=3'b011, GO=3'b111, DONE=3'b110. Enum typed.
- Next-state decoder: pre-case assignment of X, so illegal states are don't-care; no latches.
- Outputs:
  - get_ready, get_set, get_going, done and busy are Moore-decoded from the state register only.
  - grant is a register.
  - At most one phase output is high in any cycle.
- IDLE:
  - If any req bit is high, select the first set bit starting at the RR pointer, wrapping at N_REQ-1 to 0.
  - On the next edge: load that bit into grant, go to READY, load counter with ready_cycles.
  - If no req is high, stay in IDLE.
- Phase dwell:
  - A dwell value of 0 is treated as 1.
  - Each phase lasts exactly max(cfg,1) cycles.
  - The counter decrements each cycle. At count 1 the FSM advances READY to SET to GO, loading the next phase's config on the transition edge.
  - Config is sampled only when a phase is entered; changes mid-phase take effect at the next phase entry.
- GO to DONE when the GO count expires.
- DONE lasts 1 cycle:
  - done=1 and grant is still held.
  - On the next edge: go to IDLE, clear grant, RR pointer = granted index + 1, wrapping.
- Early termination, checked in READY, SET and GO:
  - Triggered by abort=1 or by the granted requester's req going low.
  - On the next edge: go to IDLE, clear grant, advance the RR pointer past the aborted index. No done pulse.
  - If abort and phase expiry occur in the same cycle, abort wins.
- Abort in IDLE or DONE is ignored; DONE always completes.
- Changes to req bits of non-granted requesters have no effect until IDLE.
- Minimum sequence with all dwells=0: READY(1), SET(1), GO(1), DONE(1), IDLE(1). That is 5 cycles from grant to the next possible grant.
- busy is high in READY, SET, GO and DONE.

Test Plan:
- Reset check: assert rstN=0 mid-GO -> all outputs 0 immediately, without waiting for a clock edge. After release with req=0, the block stays IDLE and grant=0.
- Single requester, timed phases: req=4'b0010, ready/set/go=3/2/4 -> grant=4'b0010 one cycle later. get_ready 3 cycles, get_set 2, get_going 4, done 1, then grant=0.
- Round-robin fairness: req=4'b1111 held for 3 sequences, all dwells=1 -> grants 0001, 0010, 0100 in order, each separated by one IDLE cycle.
- Wrap-around: pointer at 3, req=4'b1001 -> grant 1000 then 0001.
- Zero dwell and early drop:
  - Dwells 0/0/0 -> each phase lasts 1 cycle, done on cycle 4 after grant.
  - Granted req dropped during SET -> IDLE next edge, no done pulse.
- Abort collision: abort=1 on the final GO cycle -> IDLE, done never asserts, pointer advances. A later abort in DONE -> done still pulses.

Source files
------------

// File: rtl/rsg_sequence_arbiter.sv
// Round-robin arbiter that runs one shared READY/SET/GO phase sequence
// for the granted requester, then pulses done and releases the grant.
module rsg_sequence_arbiter #(
   parameter int N_REQ = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [N_REQ-1:0] req,
   input  logic             abort,
   input  logic [CNT_W-1:0] ready_cycles,
   input  logic [CNT_W-1:0] set_cycles,
   input  logic [CNT_W-1:0] go_cycles,
   output logic [N_REQ-1:0] grant,
   output logic             get_ready,
   output logic             get_set,
   output logic             get_going,
   output logic             done,
   output logic             busy
);

   localparam int IDX_W = $clog2(N_REQ);

   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_READY = 3'b001,
      S_SET   = 3'b011,
      S_GO    = 3'b111,
      S_DONE  = 3'b110
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [N_REQ-1:0]   r_grant;
   logic [CNT_W-1:0]   r_cnt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_gidx;
   logic [IDX_W-1:0]   w_idx [N_REQ];
   logic [IDX_W-1:0]   w_pick;
   logic [IDX_W-1:0]   w_nxt_ptr;
   logic               w_hit;
   logic               w_term;
   logic               w_exp;

   function automatic logic [CNT_W-1:0] f_dwell(input logic [CNT_W-1:0] c);
      return (c == '0) ? CNT_W'(1) : c;
   endfunction

   // Candidate indices in priority order, starting at the RR pointer
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         w_idx[i] = (int'(r_ptr) + i >= N_REQ) ?
                    IDX_W'(int'(r_ptr) + i - N_REQ) :
                    IDX_W'(int'(r_ptr) + i);
      end
   end

   always_comb begin
      w_hit  = 1'b0;
      w_pick = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!w_hit && req[w_idx[i]]) begin
            w_hit  = 1'b1;
            w_pick = w_idx[i];
         end
      end
   end

   assign w_nxt_ptr = (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;
   assign w_term    = abort | ~req[r_gidx];
   assign w_exp     = (r_cnt == CNT_W'(1));

   always_comb begin
      w_next = state_t'(3'bxxx);
      case (r_state)
         S_IDLE:  w_next = w_hit ? S_READY : S_IDLE;
         S_READY: w_next = w_term ? S_IDLE : (w_exp ? S_SET  : S_READY);
         S_SET:   w_next = w_term ? S_IDLE : (w_exp ? S_GO   : S_SET);
         S_GO:    w_next = w_term ? S_IDLE : (w_exp ? S_DONE : S_GO);
         S_DONE:  w_next = S_IDLE;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_grant <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_gidx  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hit) begin
                  r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
                  r_gidx  <= w_pick;
                  r_cnt   <= f_dwell(ready_cycles);
               end
            end
            S_READY, S_SET, S_GO: begin
               if (w_term) begin
                  r_grant <= '0;
                  r_ptr   <= w_nxt_ptr;
                  r_cnt   <= '0;
               end else if (w_exp) begin
                  // Next phase config is sampled only on entry
                  if (r_state == S_READY)    r_cnt <= f_dwell(set_cycles);
                  else if (r_state == S_SET) r_cnt <= f_dwell(go_cycles);
                  else                       r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               r_grant <= '0;
               r_ptr   <= w_nxt_ptr;
            end
            default: begin
               r_grant <= '0;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign grant     = r_grant;
   assign get_ready = (r_state == S_READY);
   assign get_set   = (r_state == S_SET);
   assign get_going = (r_state == S_GO);
   assign done      = (r_state == S_DONE);
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_rsg_sequence_arbiter.sv
// Directed bench for rsg_sequence_arbiter: phases, round robin,
// wrap, zero dwell, early drop, abort collision and async reset.
module tb_rsg_sequence_arbiter;

   logic       clk;
   logic       rstN;
   logic [3:0] req;
   logic       abort;
   logic [7:0] ready_cycles;
   logic [7:0] set_cycles;
   logic [7:0] go_cycles;
   logic [3:0] grant;
   logic       get_ready;
   logic       get_set;
   logic       get_going;
   logic       done;
   logic       busy;

   int tot = 0;
   int bad = 0;

   // expected flag fields: {get_ready,get_set,get_going,done,busy}
   localparam logic [4:0] F_IDLE  = 5'b00000;
   localparam logic [4:0] F_READY = 5'b10001;
   localparam logic [4:0] F_SET   = 5'b01001;
   localparam logic [4:0] F_GO    = 5'b00101;
   localparam logic [4:0] F_DONE  = 5'b00011;

   rsg_sequence_arbiter #(.N_REQ(4), .CNT_W(8)) dut (
      .clk          (clk),
      .rstN         (rstN),
      .req          (req),
      .abort        (abort),
      .ready_cycles (ready_cycles),
      .set_cycles   (set_cycles),
      .go_cycles    (go_cycles),
      .grant        (grant),
      .get_ready    (get_ready),
      .get_set      (get_set),
      .get_going    (get_going),
      .done         (done),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] g,
                      input logic [4:0] f);
      logic [8:0] o;
      logic [8:0] e;
      o = {grant, get_ready, get_set, get_going, done, busy};
      e = {g, f};
      tot++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   // Starts on the first READY sample, ends on the IDLE sample after DONE
   task automatic seq(input string tag, input logic [3:0] g,
                      input int nr, input int ns, input int ng);
      for (int i = 0; i < nr; i++) begin
         chk({tag, "_ready"}, g, F_READY); cyc();
      end
      for (int i = 0; i < ns; i++) begin
         chk({tag, "_set"}, g, F_SET); cyc();
      end
      for (int i = 0; i < ng; i++) begin
         chk({tag, "_go"}, g, F_GO); cyc();
      end
      chk({tag, "_done"}, g, F_DONE); cyc();
      chk({tag, "_idle"}, 4'b0000, F_IDLE);
   endtask

   initial begin
      rstN = 1'b0;
      req = 4'b0000;
      abort = 1'b0;
      ready_cycles = 8'd0;
      set_cycles = 8'd0;
      go_cycles = 8'd0;
      #22;
      chk("reset_state", 4'b0000, F_IDLE);
      rstN = 1'b1;
      cyc();
      chk("idle_after_rst", 4'b0000, F_IDLE);

      // single requester, 3/2/4
      req = 4'b0010;
      ready_cycles = 8'd3; set_cycles = 8'd2; go_cycles = 8'd4;
      cyc();
      seq("single", 4'b0010, 3, 2, 4);
      req = 4'b0000;

      // async reset in the middle of GO
      req = 4'b0001;
      ready_cycles = 8'd1; set_cycles = 8'd1; go_cycles = 8'd5;
      cyc();
      chk("pre_rst_ready", 4'b0001, F_READY);
      cyc(); cyc(); cyc();
      chk("pre_rst_go", 4'b0001, F_GO);
      #2;
      rstN = 1'b0;
      #1;
      chk("async_rst", 4'b0000, F_IDLE);
      req = 4'b0000;
      #1;
      rstN = 1'b1;
      cyc();
      chk("post_rst_idle1", 4'b0000, F_IDLE);
      cyc();
      chk("post_rst_idle2", 4'b0000, F_IDLE);

      // round robin, all requesting, dwell 1
      req = 4'b1111;
      ready_cycles = 8'd1; set_cycles = 8'd1; go_cycles = 8'd1;
      cyc();
      seq("rr0", 4'b0001, 1, 1, 1);
      cyc();
      seq("rr1", 4'b0010, 1, 1, 1);
      cyc();
      seq("rr2", 4'b0100, 1, 1, 1);

      // wrap from pointer 3, then zero dwells
      req = 4'b1001;
      cyc();
      seq("wrap3", 4'b1000, 1, 1, 1);
      ready_cycles = 8'd0; set_cycles = 8'd0; go_cycles = 8'd0;
      cyc();
      seq("wrap0_zero", 4'b0001, 1, 1, 1);

      // granted req dropped during SET
      req = 4'b0100;
      ready_cycles = 8'd2; set_cycles = 8'd3; go_cycles = 8'd2;
      cyc();
      chk("drop_ready1", 4'b0100, F_READY);
      cyc();
      chk("drop_ready2", 4'b0100, F_READY);
      cyc();
      chk("drop_set", 4'b0100, F_SET);
      req = 4'b0000;
      cyc();
      chk("drop_idle", 4'b0000, F_IDLE);
      cyc();
      chk("drop_no_done", 4'b0000, F_IDLE);

      // abort on the final GO cycle, pointer 3 -> picks index 1
      req = 4'b0010;
      ready_cycles = 8'd1; set_cycles = 8'd1; go_cycles = 8'd2;
      cyc();
      chk("ab_ready", 4'b0010, F_READY);
      cyc();
      chk("ab_set", 4'b0010, F_SET);
      cyc();
      chk("ab_go1", 4'b0010, F_GO);
      cyc();
      chk("ab_go2", 4'b0010, F_GO);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("ab_idle", 4'b0000, F_IDLE);

      // pointer must now be 2: 0110 grants index 2
      req = 4'b0110;
      ready_cycles = 8'd0; set_cycles = 8'd0; go_cycles = 8'd0;
      cyc();
      chk("ab_ptr", 4'b0100, F_READY);
      cyc();
      chk("dab_set", 4'b0100, F_SET);
      cyc();
      chk("dab_go", 4'b0100, F_GO);
      cyc();
      chk("dab_done", 4'b0100, F_DONE);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk("dab_idle", 4'b0000, F_IDLE);
      cyc();
      chk("dab_next", 4'b0010, F_READY);
      req = 4'b0000;
      cyc();
      chk("final_idle", 4'b0000, F_IDLE);

      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule
